// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame reader.
//   - Raster constants for the 640x480 @ 800x525 timing and pipeline latency.
//   - Source-select mode enum and the RGB332 colour type.
//   - Colour-bar table and RGB332 -> 24-bit expansion helper.
//   - Control word carried down the timing delay line.
package vga_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2
    } mode_e;

    typedef logic [7:0] rgb332_t;

    // Bar 0 (leftmost) sits in the low byte:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [63:0] BAR_TABLE = {
        8'h00, 8'h03, 8'hE0, 8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF
    };

    typedef struct packed {
        logic    hsync_n;
        logic    vsync_n;
        logic    blank_n;
        logic    frame_start;
        logic    use_fb;
        rgb332_t color;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE = '{
        hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0,
        frame_start: 1'b0, use_fb: 1'b0, color: 8'h00
    };

    function automatic rgb332_t bar_color(input logic [2:0] idx);
        return BAR_TABLE[{idx, 3'b000} +: 8];
    endfunction

    // Mode 3 is folded onto the solid-colour source.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_FB;
            2'd1:    return MODE_BARS;
            default: return MODE_SOLID;
        endcase
    endfunction

    function automatic logic [23:0] expand_rgb332(input rgb332_t c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with an asynchronous reset value.
//   clock   : rising-edge clock
//   reset   : asynchronous active-high reset, loads RESET_VALUE into every stage
//   sample  : value entering the line
//   delayed : value that entered DEPTH clocks earlier
module vga_delay_line #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= sample;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign delayed = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// Turns raster position/timing into pixel colour with a fixed 4-cycle latency.
// Sources: 2x-upscaled RGB332 framebuffer, colour bars, or a solid colour.
//   vga_clock, reset                : pixel clock, async active-high reset
//   hcount, vcount                  : raster position from the timing generator
//   hsync_n, vsync_n, blank_n       : timing, coincident with hcount/vcount
//   mode, bg_color                  : source select (latched per frame), solid colour
//   fb_rd_en, fb_rd_addr            : framebuffer read request (registered)
//   fb_rd_data                      : read data, two cycles after the request
//   vga_r/g/b, vga_*sync_n, blank_n : aligned pixel output
//   frame_start                     : pulse with output pixel (0,0)
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int unsigned FB_W = 320,
    parameter int unsigned FB_H = 240
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        blank_n,
    input  logic [1:0]  mode,
    input  logic [7:0]  bg_color,
    output logic        fb_rd_en,
    output logic [16:0] fb_rd_addr,
    input  logic [7:0]  fb_rd_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync_n,
    output logic        vga_vsync_n,
    output logic        vga_blank_n,
    output logic        frame_start
);

    logic        frame_origin;
    logic        line_end;
    mode_e       mode_q;
    mode_e       mode_eff;
    logic [16:0] row_base_q;
    logic [6:0]  bar_cnt_q, bar_cnt_cur;
    logic [2:0]  bar_idx_q, bar_idx_cur;
    pipe_ctrl_t  ctrl_in, ctrl_out;

    assign frame_origin = (hcount == '0) && (vcount == '0);
    assign line_end     = (hcount == 10'(H_TOTAL - 1));

    // At the frame origin the newly latched mode already governs pixel (0,0),
    // so the whole frame uses a single source.
    assign mode_eff = frame_origin ? decode_mode(mode) : mode_q;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_FB;
        end else if (frame_origin) begin
            mode_q <= decode_mode(mode);
        end
    end

    // Each framebuffer row serves two output lines: advance after odd lines.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            row_base_q <= '0;
        end else if (line_end) begin
            if (vcount == 10'(V_TOTAL - 1)) begin
                row_base_q <= '0;
            end else if (vcount[0] && (vcount < 10'(2 * FB_H - 1))) begin
                row_base_q <= row_base_q + 17'(FB_W);
            end
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
        end else begin
            fb_rd_en   <= blank_n && (mode_eff == MODE_FB);
            fb_rd_addr <= row_base_q + 17'(hcount[9:1]);
        end
    end

    // Bar position tracks hcount; forced to the left edge at hcount == 0.
    always_comb begin
        bar_cnt_cur = (hcount == '0) ? '0 : bar_cnt_q;
        bar_idx_cur = (hcount == '0) ? '0 : bar_idx_q;
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (bar_cnt_cur == 7'(BAR_W - 1)) begin
            bar_cnt_q <= '0;
            bar_idx_q <= bar_idx_cur + 3'd1;
        end else begin
            bar_cnt_q <= bar_cnt_cur + 7'd1;
            bar_idx_q <= bar_idx_cur;
        end
    end

    always_comb begin
        ctrl_in             = CTRL_IDLE;
        ctrl_in.hsync_n     = hsync_n;
        ctrl_in.vsync_n     = vsync_n;
        ctrl_in.blank_n     = blank_n;
        ctrl_in.frame_start = frame_origin;
        ctrl_in.use_fb      = (mode_eff == MODE_FB);
        ctrl_in.color       = (mode_eff == MODE_BARS) ? bar_color(bar_idx_cur) : bg_color;
    end

    // Three stages here plus the output register match address + memory latency.
    vga_delay_line #(
        .WIDTH       ($bits(pipe_ctrl_t)),
        .DEPTH       (PIPE_LAT - 1),
        .RESET_VALUE (CTRL_IDLE)
    ) u_ctrl_delay (
        .clock   (vga_clock),
        .reset   (reset),
        .sample  (ctrl_in),
        .delayed (ctrl_out)
    );

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync_n <= 1'b1;
            vga_vsync_n <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_hsync_n <= ctrl_out.hsync_n;
            vga_vsync_n <= ctrl_out.vsync_n;
            vga_blank_n <= ctrl_out.blank_n;
            frame_start <= ctrl_out.frame_start;
            if (ctrl_out.blank_n) begin
                {vga_r, vga_g, vga_b} <=
                    expand_rgb332(ctrl_out.use_fb ? fb_rd_data : ctrl_out.color);
            end else begin
                {vga_r, vga_g, vga_b} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

    localparam int FB_W = 320;
    localparam int FB_H = 240;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        hsync_n, vsync_n, blank_n;
    logic [1:0]  mode;
    logic [7:0]  bg_color;
    logic        fb_rd_en;
    logic [16:0] fb_rd_addr;
    logic [7:0]  fb_rd_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync_n, vga_vsync_n, vga_blank_n, frame_start;

    always #5 clk = ~clk;

    vga_frame_reader #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .vga_clock   (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .blank_n     (blank_n),
        .mode        (mode),
        .bg_color    (bg_color),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_addr  (fb_rd_addr),
        .fb_rd_data  (fb_rd_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hsync_n (vga_hsync_n),
        .vga_vsync_n (vga_vsync_n),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start)
    );

    // Memory: word = low address byte, two cycles after the registered request.
    // Unrequested cycles return garbage.
    logic [7:0] mem_s1 = 8'h00, mem_s2 = 8'h00;
    always @(posedge clk) begin
        mem_s1 <= fb_rd_en ? fb_rd_addr[7:0] : 8'($urandom);
        mem_s2 <= mem_s1;
    end
    assign fb_rd_data = mem_s2;

    typedef struct {
        logic        hs, vs, bl, fs;
        logic        chk_color;
        logic [23:0] rgb;
        int          h, v, fmode;
        logic [7:0]  bg;
    } exp_t;

    typedef struct {
        logic        en;
        logic        chk_addr;
        logic [16:0] addr;
    } rd_exp_t;

    typedef struct {
        int          fmode, h, v;
        logic [7:0]  bg;
        logic [23:0] rgb;
        int          hits;
    } probe_t;

    exp_t    pipe_q[$];
    rd_exp_t rd_cur, rd_next;
    probe_t  probes[11];
    int      errors = 0, checks = 0;
    int      frame_mode = 0;
    bit      color_ok = 0, was_rst = 0, full_line = 0;
    bit      watch_release = 0, count_rd = 0;
    int      since_release = 0, rd_count = 0;
    logic [1:0] mode_nxt;
    logic [7:0] bg_nxt;

    function automatic logic [23:0] expand(input logic [7:0] c);
        logic [2:0] r, g;
        logic [1:0] b;
        r = c[7:5]; g = c[4:2]; b = c[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model_pixel(input int h, input int v, input int fm,
                                                input logic [7:0] bg);
        logic [16:0] a;
        if (h >= 640 || v >= 480) return 24'h0;
        a = 17'((v / 2) * FB_W + h / 2);
        case (fm)
            0:       return expand(a[7:0]);
            1:       return bar_rgb(h / 80);
            default: return expand(bg);
        endcase
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.fs = 1'b0;
        e.chk_color = 1'b1; e.rgb = 24'h0;
        e.h = -1; e.v = -1; e.fmode = -1; e.bg = 8'h00;
        return e;
    endfunction

    function automatic bit is_short(input int h);
        return h <= 3 || h == 639 || h == 640 || (h >= 655 && h <= 657) ||
               h == 751 || h == 752 || h >= 798;
    endfunction

    task automatic check(input string name, input int h, input int v,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", name, h, v, act, req);
        end
    endtask

    // One pixel clock: drive inputs after the edge, sample at the falling edge.
    task automatic step(input int h, input int v, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        hcount   = 10'(h);
        vcount   = 10'(v);
        hsync_n  = !(h >= 656 && h < 752);
        vsync_n  = !(v >= 490 && v < 492);
        blank_n  = (h < 640) && (v < 480);
        mode     = mode_nxt;
        bg_color = bg_nxt;
        if (rst) begin
            if (!was_rst) begin
                pipe_q.delete();
                repeat (4) pipe_q.push_back(idle_exp());
            end
            pipe_q.push_back(idle_exp());
            rd_cur.en = 1'b0; rd_cur.chk_addr = 1'b1; rd_cur.addr = '0;
            rd_next = rd_cur;
            frame_mode = 0;
            color_ok = 0;
        end else begin
            if (h == 0 && v == 0) begin
                frame_mode = (mode == 2'd3) ? 2 : int'(mode);
                color_ok = 1;
            end
            e.hs = hsync_n; e.vs = vsync_n; e.bl = blank_n; e.fs = (h == 0 && v == 0);
            e.h = h; e.v = v; e.fmode = frame_mode; e.bg = bg_color;
            e.rgb = model_pixel(h, v, frame_mode, bg_color);
            e.chk_color = color_ok && (full_line || frame_mode != 1);
            pipe_q.push_back(e);
            rd_next.en       = blank_n && frame_mode == 0;
            rd_next.chk_addr = color_ok && blank_n;
            rd_next.addr     = 17'((v / 2) * FB_W + h / 2);
        end
        was_rst = rst;

        @(negedge clk);
        e = pipe_q.pop_front();
        check("sync/blank", e.h, e.v, {29'd0, vga_hsync_n, vga_vsync_n, vga_blank_n},
              {29'd0, e.hs, e.vs, e.bl});
        check("frame_start", e.h, e.v, {31'd0, frame_start}, {31'd0, e.fs});
        if (e.chk_color)
            check("colour", e.h, e.v, {8'd0, vga_r, vga_g, vga_b}, {8'd0, e.rgb});
        check("fb_rd_en", h, v, {31'd0, fb_rd_en}, {31'd0, rd_cur.en});
        if (rd_cur.chk_addr)
            check("fb_rd_addr", h, v, {15'd0, fb_rd_addr}, {15'd0, rd_cur.addr});
        for (int i = 0; i < 11; i++) begin
            if (e.chk_color && e.fmode == probes[i].fmode && e.h == probes[i].h &&
                e.v == probes[i].v && (probes[i].fmode != 2 || e.bg == probes[i].bg)) begin
                check("probe", e.h, e.v, {8'd0, vga_r, vga_g, vga_b}, {8'd0, probes[i].rgb});
                probes[i].hits++;
            end
        end
        if (watch_release && !rst) begin
            check("release frame_start", h, v, {31'd0, frame_start},
                  {31'd0, since_release == 4});
            if (since_release < 4)
                check("release idle", h, v, {7'd0, vga_r, vga_g, vga_b, vga_blank_n},
                      32'd0);
            since_release++;
            if (since_release > 6) watch_release = 0;
        end
        if (count_rd && fb_rd_en) rd_count++;
        rd_cur = rd_next;
    endtask

    task automatic run_frame(input int m0, input logic [7:0] bg0, input int chg_v,
                             input int m1, input logic [7:0] bg1, input int rst_v,
                             input int f0, input int f1, input int f2);
        int rst_left;
        mode_nxt = 2'(m0);
        bg_nxt   = bg0;
        for (int v = 0; v < 525; v++) begin
            if (v == chg_v) begin
                mode_nxt = 2'(m1);
                bg_nxt   = bg1;
            end
            full_line = (v == f0) || (v == f1) || (v == f2);
            rst_left  = (v == rst_v) ? 3 : 0;
            for (int h = 0; h < 800; h++) begin
                if (full_line || is_short(h)) begin
                    step(h, v, rst_left > 0);
                    if (rst_left > 0) rst_left--;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; hcount = '0; vcount = '0;
        hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b0;
        mode = '0; bg_color = '0; mode_nxt = '0; bg_nxt = '0;
        rd_cur.en = 1'b0; rd_cur.chk_addr = 1'b1; rd_cur.addr = '0;
        rd_next = rd_cur;

        // {frame mode, h, v, bg, expected colour}
        probes[0]  = '{0, 0,   0,   8'h00, 24'h000000, 0};
        probes[1]  = '{0, 2,   2,   8'h00, 24'h490055, 0};
        probes[2]  = '{0, 639, 479, 8'h00, 24'hFFFFFF, 0};
        probes[3]  = '{0, 700, 2,   8'h00, 24'h000000, 0};
        probes[4]  = '{1, 0,   10,  8'h00, 24'hFFFFFF, 0};
        probes[5]  = '{1, 80,  10,  8'h00, 24'hFFFF00, 0};
        probes[6]  = '{1, 240, 10,  8'h00, 24'h00FF00, 0};
        probes[7]  = '{1, 400, 10,  8'h00, 24'hFF0000, 0};
        probes[8]  = '{1, 639, 10,  8'h00, 24'h000000, 0};
        probes[9]  = '{1, 700, 10,  8'h00, 24'h000000, 0};
        probes[10] = '{2, 100, 50,  8'hE0, 24'hFF0000, 0};

        // Reset for 10 cycles, released on the frame origin.
        for (int h = 790; h < 800; h++) step(h, 524, 1'b1);
        watch_release = 1;

        // Framebuffer frame; switch to solid red at line 100.
        run_frame(0, 8'h00, 100, 2, 8'hE0, -1, 2, 10, 479);

        // Solid frame: no framebuffer reads; switch to bars mid-frame.
        rd_count = 0;
        count_rd = 1;
        run_frame(2, 8'hE0, 300, 1, 8'hE0, -1, 50, 51, 400);
        count_rd = 0;
        check("reads in solid frame", 0, 0, 32'(rd_count), 32'd0);

        // Bars frame with a 3-cycle reset at line 200; framebuffer next.
        run_frame(1, 8'hE0, 250, 0, 8'h00, 200, 10, 200, 479);
        run_frame(0, 8'h00, -1, 0, 8'h00, -1, 0, 1, 479);

        for (int f = 0; f < 2; f++) begin
            run_frame($urandom_range(0, 3), 8'($urandom), $urandom_range(1, 524),
                      $urandom_range(0, 3), 8'($urandom),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 524) : -1,
                      $urandom_range(0, 524), $urandom_range(0, 524),
                      $urandom_range(0, 524));
        end

        for (int i = 0; i < 11; i++) begin
            checks++;
            if (probes[i].hits == 0) begin
                errors++;
                $display("FAIL probe never reached at h=%0d v=%0d mode=%0d: got 0 hits required >0",
                         probes[i].h, probes[i].v, probes[i].fmode);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
